// File: rtl/riscv_mem_pkg.sv
// Shared types and helpers for the riscv_cpu data memory controller.
// Optional misaligned-access error checking is enabled by the DMEM_MISALIGN_ERR_EN macro.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_e;

    localparam int BYTES    = 4;
    localparam int WS_CNT_W = 4;

    // Byte offset from the base is wrapped to the address width, so addresses below
    // the base show up as huge offsets and fall out of range naturally.
    function automatic logic [63:0] word_idx(input logic [63:0] addr,
                                             input logic [63:0] base,
                                             input int unsigned addrWidth,
                                             input int unsigned lsbBits);
        logic [63:0] offset;
        offset = addr - base;
        if (addrWidth < 64) begin
            offset = offset & ((64'd1 << addrWidth) - 64'd1);
        end
        return offset >> lsbBits;
    endfunction

endpackage

// File: rtl/mem_byte_ram.sv
// Word-organised RAM with per-byte write enables and a registered read port.
// Read and write on the same edge return the old word (read-before-write).
module mem_byte_ram #(
   parameter int    DATA_WIDTH  = 32,
   parameter int    DEPTH_WORDS = 1024,
   parameter string INIT_FILE   = ""
) (
   input  logic                                   clk,
   input  logic                                   re_i,
   input  logic [DATA_WIDTH/8-1:0]                we_i,
   input  logic [$clog2(DEPTH_WORDS > 1 ? DEPTH_WORDS : 2)-1:0] idx_i,
   input  logic [DATA_WIDTH-1:0]                  wdata_i,
   output logic [DATA_WIDTH-1:0]                  rdata_o
);

   localparam int NumBytes = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
   logic [DATA_WIDTH-1:0] rdata_q;

   // Registered read of the addressed word, then commit of each enabled byte lane;
   // nonblocking updates make a same-edge read return the pre-write contents.
   always_ff @(posedge clk) begin
      if (re_i) begin
         rdata_q <= mem[idx_i];
      end
      for (int b = 0; b < NumBytes; b++) begin
         if (we_i[b]) begin
            mem[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/riscv_dmem_ctrl.sv
// Data memory controller: valid/ready request and response around a byte-enabled RAM,
// with programmable wait states and range checking; DMEM_MISALIGN_ERR_EN adds alignment errors.
module riscv_dmem_ctrl
    import riscv_mem_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 8 * BYTES,
    parameter int                    DEPTH_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0,
    parameter string                 INIT_FILE   = ""
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [DATA_WIDTH/8-1:0] req_we_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o
);

    localparam int NumBytes = DATA_WIDTH / 8;
    localparam int LsbBits  = $clog2(NumBytes);
    localparam int IdxW     = $clog2(DEPTH_WORDS > 1 ? DEPTH_WORDS : 2);

    dmem_state_e           state_q, state_d;
    logic [WS_CNT_W-1:0]   waitCnt_q, waitCnt_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [NumBytes-1:0]   we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  pendErr_q, pendErr_d;
    logic                  rspValid_q, rspValid_d;
    logic                  rspErr_q, rspErr_d;

    logic                  ramRe;
    logic [NumBytes-1:0]   ramWe;
    logic [DATA_WIDTH-1:0] ramRdata;
    logic [63:0]           idxFull;
    logic                  outOfRange;
    logic                  misaligned;

    always_comb begin
        idxFull    = word_idx(64'(req_addr_i), 64'(BASE_ADDR), ADDR_WIDTH, LsbBits);
        outOfRange = (idxFull >= 64'(DEPTH_WORDS));
    end

`ifdef DMEM_MISALIGN_ERR_EN
    logic [ADDR_WIDTH-1:0] lowBits;
    logic [NumBytes-1:0]   byteMask;
    logic [NumBytes-1:0]   halfMask;

    // A non-zero offset is legal only for a single byte at that offset or an even-offset halfword.
    always_comb begin
        lowBits    = req_addr_i & ADDR_WIDTH'(NumBytes - 1);
        byteMask   = NumBytes'(1) << lowBits;
        halfMask   = NumBytes'(3) << lowBits;
        misaligned = 1'b0;
        if (lowBits != '0) begin
            misaligned = (req_we_i == '0) ||
                         !((req_we_i == byteMask) || (!lowBits[0] && (req_we_i == halfMask)));
        end
    end
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            waitCnt_q  <= '0;
            idx_q      <= '0;
            we_q       <= '0;
            wdata_q    <= '0;
            pendErr_q  <= 1'b0;
            rspValid_q <= 1'b0;
            rspErr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            waitCnt_q  <= waitCnt_d;
            idx_q      <= idx_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            pendErr_q  <= pendErr_d;
            rspValid_q <= rspValid_d;
            rspErr_q   <= rspErr_d;
        end
    end

    // The access edge is the WAIT cycle whose counter is already zero, giving WAIT_STATES+1 latency.
    always_comb begin
        state_d     = state_q;
        waitCnt_d   = waitCnt_q;
        idx_d       = idx_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        pendErr_d   = pendErr_q;
        rspValid_d  = rspValid_q;
        rspErr_d    = rspErr_q;
        ramRe       = 1'b0;
        ramWe       = '0;
        req_ready_o = 1'b0;

        unique case (state_q)
            IDLE: begin
                req_ready_o = !rst;
                if (req_valid_i) begin
                    idx_d     = idxFull[IdxW-1:0];
                    we_d      = req_we_i;
                    wdata_d   = req_wdata_i;
                    pendErr_d = outOfRange || misaligned;
                    waitCnt_d = WS_CNT_W'(WAIT_STATES);
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (waitCnt_q == '0) begin
                    ramRe      = 1'b1;
                    ramWe      = (rst || pendErr_q) ? '0 : we_q;
                    rspValid_d = 1'b1;
                    rspErr_d   = pendErr_q;
                    state_d    = RESP;
                end else begin
                    waitCnt_d = waitCnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rspValid_d = 1'b0;
                    rspErr_d   = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    mem_byte_ram #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS),
        .INIT_FILE   (INIT_FILE)
    ) u_ram (
        .clk     (clk),
        .re_i    (ramRe),
        .we_i    (ramWe),
        .idx_i   (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (ramRdata)
    );

    assign rsp_valid_o = rspValid_q;
    assign rsp_err_o   = rspErr_q;
    assign rsp_rdata_o = (rspValid_q && !rspErr_q) ? ramRdata : '0;

endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
// Self-checking bench for riscv_dmem_ctrl with three wait states and a word-level reference memory.
// Expectations follow DMEM_MISALIGN_ERR_EN when the macro is defined for the build.
module tb_riscv_dmem_ctrl;

    localparam int WS    = 3;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic [3:0]  req_we_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;

    int checks   = 0;
    int failures = 0;

    logic [31:0] refMem [int];

    riscv_dmem_ctrl #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (32'h0),
        .WAIT_STATES (WS),
        .INIT_FILE   ("")
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_we_i    (req_we_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Legal unaligned accesses are a lone byte at its offset or a halfword at an even offset.
    function automatic logic misalignedRef(input logic [31:0] addr, input logic [3:0] we);
        int off, n, lo, hi;
        off = int'(addr % 4);
        if (off == 0) return 1'b0;
        if (we == 4'h0) return 1'b1;
        n  = 0;
        lo = -1;
        hi = -1;
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                n++;
                if (lo < 0) lo = b;
                hi = b;
            end
        end
        return !((hi - lo + 1 == n) && (n <= 2) && (lo == off) && (off % n == 0));
    endfunction

    function automatic void modelAccess(input logic [31:0] addr, input logic [3:0] we,
                                        input logic [31:0] wdata,
                                        output logic [31:0] expRdata, output logic expErr);
        logic [31:0] offset;
        logic [31:0] oldWord;
        logic [31:0] newWord;
        int          w;
        offset = addr - 32'h0;
        expErr = (offset >= 32'(DEPTH * 4));
`ifdef DMEM_MISALIGN_ERR_EN
        if (misalignedRef(addr, we)) expErr = 1'b1;
`endif
        if (expErr) begin
            expRdata = 32'h0;
        end else begin
            w        = int'(offset / 4);
            oldWord  = refMem.exists(w) ? refMem[w] : 32'h0;
            expRdata = oldWord;
            newWord  = oldWord;
            for (int b = 0; b < 4; b++) begin
                if (we[b]) newWord[8*b +: 8] = wdata[8*b +: 8];
            end
            refMem[w] = newWord;
        end
    endfunction

    task automatic applyStimulus(input string tag, input logic [31:0] addr, input logic [3:0] we,
                                 input logic [31:0] wdata, input int hold,
                                 output logic [31:0] rdata, output logic err);
        int          lat;
        logic        quiet;
        logic        stable;
        logic [31:0] expR;
        logic        expE;
        modelAccess(addr, we, wdata, expR, expE);
        @(negedge clk);
        req_valid_i = 1'b1;
        req_addr_i  = addr;
        req_we_i    = we;
        req_wdata_i = wdata;
        checkOutput({tag, ".ready"}, 32'(req_ready_o), 32'd1);
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        req_addr_i  = $urandom;
        req_we_i    = 4'($urandom);
        req_wdata_i = $urandom;
        lat   = 0;
        quiet = 1'b1;
        do begin
            rsp_ready_i = 1'($urandom);
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (req_ready_o !== 1'b0) quiet = 1'b0;
        end while (rsp_valid_o !== 1'b1 && lat < 40);
        rsp_ready_i = 1'b0;
        rdata = rsp_rdata_o;
        err   = rsp_err_o;
        checkOutput({tag, ".latency"}, 32'(lat), 32'(WS + 1));
        checkOutput({tag, ".busy"}, 32'(quiet), 32'd1);
        checkOutput({tag, ".rdata"}, rdata, expR);
        checkOutput({tag, ".err"}, 32'(err), 32'(expE));
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== rdata || rsp_err_o !== err || req_ready_o !== 1'b0)
                stable = 1'b0;
        end
        if (hold > 0) checkOutput({tag, ".hold"}, 32'(stable), 32'd1);
        rsp_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready_i = 1'b0;
        checkOutput({tag, ".release"}, {30'd0, rsp_valid_o, req_ready_o}, 32'd1);
    endtask

    initial begin
        logic [31:0] r;
        logic        e;
        logic [31:0] a;
        logic [3:0]  we;
        int          k;

        rst         = 1'b1;
        req_valid_i = 1'b0;
        req_addr_i  = '0;
        req_we_i    = '0;
        req_wdata_i = '0;
        rsp_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset.ready", 32'(req_ready_o), 32'd0);
        checkOutput("reset.valid", 32'(rsp_valid_o), 32'd0);
        checkOutput("reset.err", 32'(rsp_err_o), 32'd0);
        checkOutput("reset.rdata", rsp_rdata_o, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset.idle_ready", 32'(req_ready_o), 32'd1);

        for (int i = 0; i < 16; i++) begin
            applyStimulus("init", 32'h100 + 32'(4 * i), 4'hF, $urandom, 0, r, e);
        end
        applyStimulus("init0", 32'h0, 4'hF, 32'hCAFEF00D, 0, r, e);
        applyStimulus("init200", 32'h200, 4'hF, 32'h55AA55AA, 0, r, e);

        applyStimulus("t1.wr", 32'h100, 4'hF, 32'hDEADBEEF, 0, r, e);
        applyStimulus("t1.rd", 32'h100, 4'h0, 32'h0, 0, r, e);
        checkOutput("t1.value", r, 32'hDEADBEEF);

        applyStimulus("t2.init", 32'h104, 4'hF, 32'h11223344, 0, r, e);
        applyStimulus("t2.lane", 32'h104, 4'b0100, 32'h00AA0000, 1, r, e);
        checkOutput("t2.old", r, 32'h11223344);
        applyStimulus("t2.rd", 32'h104, 4'h0, 32'h0, 0, r, e);
        checkOutput("t2.merged", r, 32'h11AA3344);

        applyStimulus("t3.hold", 32'h104, 4'h0, 32'h0, 5, r, e);

        applyStimulus("t4.oob", 32'h1000, 4'hF, 32'h87654321, 2, r, e);
        checkOutput("t4.err", 32'(e), 32'd1);
        checkOutput("t4.zero", r, 32'h0);
        applyStimulus("t4.word0", 32'h0, 4'h0, 32'h0, 0, r, e);
        checkOutput("t4.word0_kept", r, 32'hCAFEF00D);
        applyStimulus("t4.wrap", 32'hFFFFFFFC, 4'h0, 32'h0, 0, r, e);
        checkOutput("t4.wrap_err", 32'(e), 32'd1);

        // Reset lands exactly on the access edge, so the pending write must be dropped.
        @(negedge clk);
        req_valid_i = 1'b1;
        req_addr_i  = 32'h200;
        req_we_i    = 4'hF;
        req_wdata_i = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        repeat (WS) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("t5.valid", 32'(rsp_valid_o), 32'd0);
        checkOutput("t5.ready", 32'(req_ready_o), 32'd0);
        checkOutput("t5.err", 32'(rsp_err_o), 32'd0);
        checkOutput("t5.rdata", rsp_rdata_o, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("t5.idle", 32'(req_ready_o), 32'd1);
        applyStimulus("t5.rd", 32'h200, 4'h0, 32'h0, 0, r, e);
        checkOutput("t5.old", r, 32'h55AA55AA);

        applyStimulus("t6.rd", 32'h102, 4'h0, 32'h0, 0, r, e);
`ifdef DMEM_MISALIGN_ERR_EN
        checkOutput("t6.err", 32'(e), 32'd1);
        checkOutput("t6.zero", r, 32'h0);
`else
        checkOutput("t6.err", 32'(e), 32'd0);
        checkOutput("t6.word", r, 32'hDEADBEEF);
`endif
        applyStimulus("t6.half", 32'h102, 4'b1100, 32'hBEEF0000, 0, r, e);
        applyStimulus("t6.bad", 32'h103, 4'b0110, 32'h00123400, 0, r, e);
        applyStimulus("t6.byte", 32'h101, 4'b0010, 32'h00007700, 0, r, e);
        applyStimulus("t6.check", 32'h100, 4'h0, 32'h0, 0, r, e);

        for (int i = 0; i < 40; i++) begin
            k = int'($urandom_range(0, 9));
            if (k == 0) a = $urandom | 32'h1000;
            else a = 32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0:       we = 4'h0;
                1:       we = 4'hF;
                2:       we = 4'(1 << $urandom_range(0, 3));
                3:       we = 4'(3 << (2 * $urandom_range(0, 1)));
                default: we = 4'($urandom);
            endcase
            applyStimulus("rand", a, we, $urandom, int'($urandom_range(0, 3)), r, e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
